// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: scan FSM states, blank pattern and the hex
// segment table (bit 0 = top segment, clockwise, then middle).
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } scan_state_e;

  localparam logic [0:6] SEG_BLANK = 7'b0000000;

  // Entry i is the lit pattern for hex digit i; the encoder uses the same table.
  localparam logic [0:15][0:6] SEG_TABLE = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the segment table: pattern -> hex value plus
// valid/blank classification.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [0:6] seg,
  output logic [3:0] hex,
  output logic       is_valid,
  output logic       is_blank
);

  always_comb begin
    hex      = 4'h0;
    is_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        hex      = 4'(i);
        is_valid = 1'b1;
      end
    end
  end

  assign is_blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scanned seven-segment display decoder: debounces each strobed digit and
// latches its hex value. Define SEG7_SCAN_TIMEOUT_EN to expire stale digits.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:6]  seg,
  input  logic [3:0]  dig_en,
  input  logic        err_clr,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        update,
  output logic        pattern_err
);

  scan_state_e     state, state_n;
  logic [7:0]      count, count_n;
  logic [0:6]      s_seg, r_seg;
  logic [3:0]      s_en, r_en;
  logic [3:0][3:0] dig_q;
  logic            onehot, changed, cap_go;
  logic [3:0]      dec_hex;
  logic            dec_valid, dec_blank;

  assign onehot  = (s_en != 4'b0000) && ((s_en & (s_en - 4'd1)) == 4'b0000);
  assign changed = (s_seg != r_seg) || (s_en != r_en);
  assign cap_go  = (state == SETTLE) && (state_n == CAPTURE);
  assign update  = (state == CAPTURE);
  assign digits  = dig_q;

  seg7_to_hex u_dec (
    .seg      (s_seg),
    .hex      (dec_hex),
    .is_valid (dec_valid),
    .is_blank (dec_blank)
  );

  // r_* holds the previous sample; it is frozen while leaving CAPTURE so a
  // change arriving in the capture cycle is still seen by HOLD.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= 8'd0;
      s_seg <= '0;
      s_en  <= '0;
      r_seg <= '0;
      r_en  <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      s_seg <= seg;
      s_en  <= dig_en;
      if (state != CAPTURE) begin
        r_seg <= s_seg;
        r_en  <= s_en;
      end
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    case (state)
      IDLE: if (onehot) begin
        state_n = SETTLE;
        count_n = 8'd1;
      end
      SETTLE: begin
        if (!onehot) begin
          state_n = IDLE;
          count_n = 8'd0;
        end else if (changed) begin
          count_n = 8'd1;
        end else begin
          count_n = count + 8'd1;
          if (count + 8'd1 >= 8'(STABLE_CYCLES)) state_n = CAPTURE;
        end
      end
      CAPTURE: state_n = HOLD;
      HOLD: if (changed) begin
        state_n = onehot ? SETTLE : IDLE;
        count_n = onehot ? 8'd1 : 8'd0;
      end
      default: begin
        state_n = IDLE;
        count_n = 8'd0;
      end
    endcase
  end

`ifdef SEG7_SCAN_TIMEOUT_EN
  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES);
  logic [3:0][15:0] tcnt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      dig_q       <= '0;
      digit_valid <= '0;
      pattern_err <= 1'b0;
`ifdef SEG7_SCAN_TIMEOUT_EN
      tcnt        <= '0;
`endif
    end else begin
      // A new error outranks a simultaneous clear.
      if (cap_go && !dec_valid && !dec_blank) pattern_err <= 1'b1;
      else if (err_clr)                       pattern_err <= 1'b0;
      for (int i = 0; i < 4; i++) begin
`ifdef SEG7_SCAN_TIMEOUT_EN
        if (cap_go && s_en[i]) begin
          tcnt[i] <= 16'd0;
        end else if (tcnt[i] != TMAX) begin
          tcnt[i] <= tcnt[i] + 16'd1;
          if (tcnt[i] == TMAX - 16'd1) digit_valid[i] <= 1'b0;
        end
`endif
        if (cap_go && s_en[i]) begin
          if (dec_valid) begin
            dig_q[i]       <= dec_hex;
            digit_valid[i] <= 1'b1;
          end else if (dec_blank) begin
            dig_q[i]       <= 4'h0;
            digit_valid[i] <= 1'b0;
          end else begin
            digit_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with hand-computed expectations.
module tb_seg7_scan_decoder;

  localparam int S = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [0:6]  seg;
  logic [3:0]  dig_en;
  logic        err_clr;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        update;
  logic        pattern_err;

  int n_chk = 0;
  int n_err = 0;

  seg7_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .seg         (seg),
    .dig_en      (dig_en),
    .err_clr     (err_clr),
    .digits      (digits),
    .digit_valid (digit_valid),
    .update      (update),
    .pattern_err (pattern_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs were just driven in cycle 0; expect update only in cycle exp_cyc.
  task automatic run_win(input string tag, input int ncyc, input int exp_cyc);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clock);
      chk(tag, 32'(update), 32'(n == exp_cyc));
    end
  endtask

  initial begin
    reset = 1'b1; seg = 7'b0000000; dig_en = 4'b0000; err_clr = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_digits", 32'(digits), 32'h0000);
    chk("rst_valid",  32'(digit_valid), 32'h0);
    chk("rst_update", 32'(update), 32'h0);
    chk("rst_err",    32'(pattern_err), 32'h0);

    // digit 0 = 1
    reset = 1'b0; seg = 7'b0110000; dig_en = 4'b0001;
    run_win("cap1", 6, 5);
    chk("d0_digits", 32'(digits), 32'h0001);
    chk("d0_valid",  32'(digit_valid), 32'b0001);

    // glitch 3 then settle on 5 at digit 2
    seg = 7'b1111001; dig_en = 4'b0100;
    run_win("no3", 2, 0);
    seg = 7'b1011011;
    run_win("cap5", 6, 5);
    chk("d2_nibble", 32'(digits[11:8]), 32'h5);
    chk("d2_digits", 32'(digits), 32'h0501);
    chk("d2_valid",  32'(digit_valid), 32'b0101);

    // unrecognised pattern on digit 1
    seg = 7'b1010101; dig_en = 4'b0010;
    run_win("errcap", 6, 5);
    chk("err_set",    32'(pattern_err), 32'h1);
    chk("err_valid1", 32'(digit_valid[1]), 32'h0);
    chk("err_digits", 32'(digits), 32'h0501);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    chk("err_clr", 32'(pattern_err), 32'h0);

    // repeat the error with err_clr in the capturing cycle
    dig_en = 4'b0000;
    repeat (2) @(negedge clock);
    seg = 7'b1010101; dig_en = 4'b0010;
    for (int n = 1; n <= S + 1; n++) begin
      @(negedge clock);
      err_clr = (n == S);
    end
    chk("err_win_upd", 32'(update), 32'h1);
    chk("err_win",     32'(pattern_err), 32'h1);
    @(negedge clock);
    chk("err_sticky",  32'(pattern_err), 32'h1);

    // multi-hot and no strobe never write
    seg = 7'b1111111; dig_en = 4'b0011;
    run_win("multi", 20, 0);
    dig_en = 4'b0000;
    run_win("none", 20, 0);
    chk("nowr_digits", 32'(digits), 32'h0501);

    // reset mid-SETTLE (count=3) on digit 3 = 8
    seg = 7'b1111111; dig_en = 4'b1000;
    run_win("pre_rst", 4, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("in_rst_upd", 32'(update), 32'h0);
    @(negedge clock);
    chk("in_rst_dig", 32'(digits), 32'h0000);
    reset = 1'b0;
    run_win("rst_cap", 6, 5);
    chk("rst_d3",    32'(digits), 32'h8000);
    chk("rst_valid", 32'(digit_valid), 32'b1000);
    chk("rst_err0",  32'(pattern_err), 32'h0);

    // only digit 0 strobed afterwards; digit 3 capture was at cycle k, now k+1
    seg = 7'b0110000; dig_en = 4'b0001;
    for (int m = 2; m <= 17; m++) begin
      @(negedge clock);
`ifdef SEG7_SCAN_TIMEOUT_EN
      chk("tmo_v3", 32'(digit_valid[3]), 32'(m < 16));
`else
      chk("tmo_v3", 32'(digit_valid[3]), 32'h1);
`endif
    end
    chk("tmo_d3",  32'(digits[15:12]), 32'h8);
    chk("tmo_d0",  32'(digits), 32'h8001);

    // blank pattern clears nibble and valid, no error
    seg = 7'b0000000; dig_en = 4'b0001;
    run_win("blank", 6, 5);
    chk("blank_dig",   32'(digits), 32'h8000);
    chk("blank_valid", 32'(digit_valid[0]), 32'h0);
    chk("blank_err",   32'(pattern_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical samples needed to accept a digit.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, range 16..65535: refresh window per digit; used only when SEG7_SCAN_TIMEOUT_EN is defined.
REQ-003 clock  input  1  system clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 seg  input  [0:6]  segment lines, bit 0 = top segment, bits 1..6 clockwise then middle; 1 = lit.
REQ-006 dig_en  input  4  digit strobes, active-high; exactly one bit set selects that digit.
REQ-007 err_clr  input  1  one-cycle pulse that clears pattern_err.
REQ-008 digits  output  16  decoded values; nibble i = digit i.
REQ-009 digit_valid  output  4  bit i = nibble i holds an accepted value.
REQ-010 update  output  1  one-cycle pulse when any nibble is written.
REQ-011 pattern_err  output  1  sticky flag set when an unrecognised pattern is accepted.

Function
REQ-012 seg and dig_en SHALL be registered once (sample stage) before any other use.
REQ-013 Decoding SHALL be the exact inverse of the team hex table: 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1110011, A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
REQ-014 The block SHALL use a 4-state FSM: IDLE, SETTLE, CAPTURE, HOLD.
REQ-015 IDLE: stay while sampled dig_en is not one-hot; go to SETTLE with count=1 when it is one-hot.
REQ-016 SETTLE: increment count while sampled seg and dig_en equal the previous sample; go to CAPTURE when count reaches STABLE_CYCLES; any change restarts SETTLE with count=1; loss of one-hot goes to IDLE.
REQ-017 CAPTURE lasts one cycle: write the selected nibble, pulse update, then go to HOLD.
REQ-018 HOLD: no further writes while the sample is unchanged; on a change go to SETTLE (count=1), or to IDLE if the new dig_en is not one-hot.
REQ-019 With inputs constant from cycle t, update and the new nibble SHALL be visible in cycle t+STABLE_CYCLES+1.
REQ-020 Valid pattern: nibble := decoded value, digit_valid[i] := 1.
REQ-021 Blank pattern 0000000: nibble := 0, digit_valid[i] := 0, no error.
REQ-022 Any other pattern: nibble unchanged, digit_valid[i] := 0, pattern_err := 1.
REQ-023 update SHALL pulse on every CAPTURE, including the blank and error cases.
REQ-024 If err_clr is asserted in the same cycle as a new error, the error SHALL win and pattern_err stays 1.
REQ-025 dig_en values 0000 and multi-hot SHALL never write any nibble.

Reset
REQ-026 On reset: FSM to IDLE, count 0, digits 0x0000, digit_valid 0000, update 0, pattern_err 0, sample registers 0, timeout counters 0.
REQ-027 Reset asserted mid-SETTLE SHALL discard the partial count; no update may follow from pre-reset samples.

Configuration
REQ-028 Macro SEG7_SCAN_TIMEOUT_EN defined: each digit has a counter, cleared on that digit's CAPTURE; after TIMEOUT_CYCLES cycles without a capture, digit_valid[i] := 0 (nibble retained) and the counter saturates.
REQ-029 Macro SEG7_SCAN_TIMEOUT_EN undefined: no timeout counters; digit_valid changes only per REQ-020..022 and reset.

Structure
REQ-030 Package seg7_pkg SHALL hold the FSM state enum, the blank-pattern constant, and the 16-entry segment table shared with the encoder.
REQ-031 Sub-module seg7_to_hex (combinational; inputs seg[0:6]; outputs hex[3:0], is_valid, is_blank) SHALL implement the lookup in REQ-013.

Verification
REQ-032 Reset; seg=0110000, dig_en=0001 held 6 cycles -> update in cycle 5 only; digits=0x0001; digit_valid=0001.
REQ-033 seg=1111001 on dig_en=0100 for 2 cycles, then 1011011 held -> no capture of 3; 5 is captured STABLE_CYCLES+1 cycles after the change; digits[11:8]=5.
REQ-034 seg=1010101 stable on dig_en=0010 -> pattern_err=1, digit_valid[1]=0; err_clr pulse -> pattern_err=0; error repeated with err_clr in the same cycle -> pattern_err stays 1.
REQ-035 dig_en=0011 or 0000 with seg=1111111 for 20 cycles -> no update; digits unchanged.
REQ-036 Reset asserted at SETTLE count=3, then inputs held -> first update occurs STABLE_CYCLES+1 cycles after reset release.
REQ-037 With SEG7_SCAN_TIMEOUT_EN and TIMEOUT_CYCLES=16: capture digit 3 = 8 (1111111), then strobe only digit 0 -> digit_valid[3] drops exactly 16 cycles after digit 3's CAPTURE; digits[15:12] stays 8.
